// File: rtl/r_forward_arbiter.sv
// Two-input round-robin arbiter merging filtered forward channels onto one output.
// Optional macro R_FORWARD_ARBITER_SKID_EN inserts a 2-entry skid slice on the output.
module r_forward_arbiter #(
    parameter int PRIO_INIT = 0,
    parameter int DW        = 77
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [DW-1:0] DATA0i,
    input  logic          VALID0i,
    output logic          READY0i,
    input  logic [DW-1:0] DATA1i,
    input  logic          VALID1i,
    output logic          READY1i,
    output logic [DW-1:0] DATAo,
    output logic          VALIDo,
    input  logic          READYo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state_p0;
    state_t        state_nxt;
    logic          ptr_p0;
    logic          ptr_nxt;

    logic          arb_vld;
    logic [DW-1:0] arb_data;
    logic          arb_rdy;

    always_comb begin
        state_nxt = state_p0;
        ptr_nxt   = ptr_p0;
        arb_vld   = 1'b0;
        arb_data  = DATA0i;
        READY0i   = 1'b0;
        READY1i   = 1'b0;
        case (state_p0)
            IDLE: begin
                if (VALID0i && VALID1i) begin
                    state_nxt = ptr_p0 ? GNT1 : GNT0;
                end else if (VALID0i) begin
                    state_nxt = GNT0;
                end else if (VALID1i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                arb_vld  = VALID0i;
                arb_data = DATA0i;
                READY0i  = arb_rdy;
                if (VALID0i && arb_rdy) begin
                    ptr_nxt = 1'b1;
                    if (VALID1i) begin
                        state_nxt = GNT1;
                    end else begin
                        state_nxt = GNT0;
                    end
                end else if (!VALID0i) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                arb_vld  = VALID1i;
                arb_data = DATA1i;
                READY1i  = arb_rdy;
                if (VALID1i && arb_rdy) begin
                    ptr_nxt = 1'b0;
                    if (VALID0i) begin
                        state_nxt = GNT0;
                    end else begin
                        state_nxt = GNT1;
                    end
                end else if (!VALID1i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage p0: grant state and round-robin pointer
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_p0 <= IDLE;
            ptr_p0   <= 1'(PRIO_INIT);
        end else begin
            state_p0 <= state_nxt;
            ptr_p0   <= ptr_nxt;
        end
    end

`ifdef R_FORWARD_ARBITER_SKID_EN
    logic          vld_p1;
    logic [DW-1:0] data_p1;
    logic          skid_vld_p1;
    logic [DW-1:0] skid_data_p1;

    // Arbiter only sees registered back-pressure, cutting READYo -> READYxi.
    assign arb_rdy = !skid_vld_p1;

    // stage p1: main register feeds the output, skid absorbs one word on stall
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || READYo) begin
            if (skid_vld_p1) begin
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1      <= arb_vld;
            end
        end else if (arb_vld && arb_rdy) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!vld_p1 || READYo) begin
            data_p1 <= skid_vld_p1 ? skid_data_p1 : arb_data;
        end
        if (vld_p1 && !READYo && arb_vld && arb_rdy) begin
            skid_data_p1 <= arb_data;
        end
    end

    assign DATAo  = data_p1;
    assign VALIDo = vld_p1;
`else
    assign arb_rdy = READYo;
    assign DATAo   = arb_data;
    assign VALIDo  = arb_vld;
`endif

endmodule

// File: tb/tb_r_forward_arbiter.sv
// Randomised and directed bench for r_forward_arbiter with a scoreboard and round-robin order model.
// Build with R_FORWARD_ARBITER_SKID_EN defined to exercise the skid variant.
module tb_r_forward_arbiter;
    localparam int DW   = 77;
    localparam int PRIO = 0;
`ifdef R_FORWARD_ARBITER_SKID_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [DW-1:0] DATA0i = '0;
    logic          VALID0i = 1'b0;
    logic          READY0i;
    logic [DW-1:0] DATA1i = '0;
    logic          VALID1i = 1'b0;
    logic          READY1i;
    logic [DW-1:0] DATAo;
    logic          VALIDo;
    logic          READYo = 1'b0;

    always #5 ACLK = ~ACLK;

    r_forward_arbiter #(.PRIO_INIT(PRIO), .DW(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .DATA0i(DATA0i), .VALID0i(VALID0i), .READY0i(READY0i),
        .DATA1i(DATA1i), .VALID1i(VALID1i), .READY1i(READY1i),
        .DATAo(DATAo), .VALIDo(VALIDo), .READYo(READYo)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] sb[$];
    logic          pres0 = 1'b0, pres1 = 1'b0;
    int            pv0 = 100, pv1 = 100;
    logic          hs0 = 1'b0, hs1 = 1'b0;
    logic          rst_low_prev = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int            expect_src = -1;

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    // One clock cycle: retire accepted words, drive sources, then check against the model.
    task automatic step(input logic ro, input logic rn);
        logic [DW-1:0] dummy;
        @(posedge ACLK);
        #1;
        if (hs0 && q0.size() > 0) begin dummy = q0.pop_front(); pres0 = 1'b0; end
        if (hs1 && q1.size() > 0) begin dummy = q1.pop_front(); pres1 = 1'b0; end
        if (rst_low_prev) begin
            sb.delete();
            expect_src = -1;
            stall_prev = 1'b0;
        end
        if (!pres0 && q0.size() > 0 && int'($urandom_range(99)) < pv0) pres0 = 1'b1;
        if (!pres1 && q1.size() > 0 && int'($urandom_range(99)) < pv1) pres1 = 1'b1;
        VALID0i = pres0;
        DATA0i  = pres0 ? q0[0] : rnd_word();
        VALID1i = pres1;
        DATA1i  = pres1 ? q1[0] : rnd_word();
        READYo  = ro;
        ARESETn = rn;
        #1;
        hs0 = VALID0i & READY0i;
        hs1 = VALID1i & READY1i;
        chk_b("ready_exclusive", READY0i & READY1i, 1'b0);
        if (stall_prev) begin
            chk_b("hold_valid", VALIDo, 1'b1);
            chk_w("hold_data", DATAo, stall_data);
        end
`ifndef R_FORWARD_ARBITER_SKID_EN
        chk_b("zero_latency", VALIDo & READYo, hs0 | hs1);
`endif
        if (hs0) begin
            if (expect_src >= 0) chk_i("rr_order", 0, expect_src);
            expect_src = pres1 ? 1 : -1;
            sb.push_back(DATA0i);
        end
        if (hs1) begin
            if (expect_src >= 0) chk_i("rr_order", 1, expect_src);
            expect_src = pres0 ? 0 : -1;
            sb.push_back(DATA1i);
        end
        if (VALIDo && READYo) begin
            if (sb.size() == 0) begin
                chk_i("sb_underflow", 1, 0);
            end else begin
                chk_w("sb_data", DATAo, sb.pop_front());
            end
        end
        stall_prev = VALIDo && !READYo && rn;
        stall_data = DATAo;
        if (rst_low_prev && rn && pres0 && pres1) expect_src = PRIO;
        rst_low_prev = !rn;
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        pres0 = 1'b0;
        pres1 = 1'b0;
        hs0 = 1'b0;
        hs1 = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_b("rst_validO", VALIDo, 1'b0);
    endtask

    logic [DW-1:0] alt_exp [4];
    logic [DW-1:0] lit;
    logic [DW-1:0] w0a, w1a, cap;

    initial begin
        alt_exp = '{77'h0AAA0000, 77'h0BBB0000, 77'h0AAA0001, 77'h0BBB0001};

        // Reset held with both sources valid
        for (int n = 0; n < 8; n++) begin
            q0.push_back(77'h0AAA0000 + 77'(n));
            q1.push_back(77'h0BBB0000 + 77'(n));
        end
        pv0 = 100; pv1 = 100;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk_b("reset_validO", VALIDo, 1'b0);
            chk_b("reset_ready0", READY0i, 1'b0);
            chk_b("reset_ready1", READY1i, 1'b0);
        end

        // Contention with READYo=1: strict alternation starting from source 0
        step(1'b1, 1'b1);
        chk_b("alt_idle_valid", VALIDo, 1'b0);
        for (int k = 1; k <= 4 + LAT; k++) begin
            step(1'b1, 1'b1);
            if (k <= LAT) begin
                chk_b("alt_latency", VALIDo, 1'b0);
            end else begin
                chk_b("alt_valid", VALIDo, 1'b1);
                chk_w("alt_data", DATAo, alt_exp[k-1-LAT]);
            end
        end

        // Single source stalled five cycles
        do_reset();
        lit = 77'h1_2345_6789_ABCD_EF01;
        q1.push_back(lit);
        pv0 = 0; pv1 = 100;
        step(1'b0, 1'b1);
        chk_b("stall_idle_valid", VALIDo, 1'b0);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i == 5, 1'b1);
            chk_b("stall_valid", VALIDo, 1'b1);
            chk_w("stall_data", DATAo, lit);
`ifndef R_FORWARD_ARBITER_SKID_EN
            chk_b("stall_ready1", READY1i, i == 5);
`endif
        end
        step(1'b0, 1'b1);
        chk_b("stall_done", VALIDo, 1'b0);

        // Grant 0 stalled while source 1 rises
        do_reset();
        w0a = rnd_word();
        w1a = rnd_word();
        q0.push_back(w0a);
        q1.push_back(w1a);
        pv0 = 100; pv1 = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        pv1 = 100;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk_w("gnt_hold_data", DATAo, w0a);
`ifndef R_FORWARD_ARBITER_SKID_EN
        chk_b("gnt_hold_ready1", READY1i, 1'b0);
`endif
        step(1'b1, 1'b1);
        chk_b("gnt_acc_valid", VALIDo, 1'b1);
        chk_w("gnt_acc_data", DATAo, w0a);
        step(1'b1, 1'b1);
        chk_b("gnt_next_valid", VALIDo, 1'b1);
        chk_w("gnt_next_data", DATAo, w1a);

        // Reset while the output is valid
        do_reset();
        for (int n = 0; n < 6; n++) begin
            q0.push_back(rnd_word());
            q1.push_back(rnd_word());
        end
        pv0 = 100; pv1 = 100;
        for (int i = 0; i < 2 + LAT; i++) step(1'b0, 1'b1);
        chk_b("mid_valid", VALIDo, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk_b("mid_rst_valid", VALIDo, 1'b0);
        chk_b("mid_rst_ready0", READY0i, 1'b0);
        chk_b("mid_rst_ready1", READY1i, 1'b0);
        cap = q0[0];
        for (int i = 0; i < 1 + LAT; i++) step(1'b1, 1'b1);
        chk_b("mid_restart_valid", VALIDo, 1'b1);
        chk_w("mid_restart_data", DATAo, cap);

        // Toggling READYo with both sources valid
        do_reset();
        for (int n = 0; n < 10; n++) begin
            q0.push_back(rnd_word());
            q1.push_back(rnd_word());
        end
        pv0 = 100; pv1 = 100;
        for (int i = 0; i < 30; i++) step(i % 2 == 0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        chk_i("toggle_drain_sb", sb.size(), 0);
        chk_i("toggle_drain_q", q0.size() + q1.size(), 0);

        // Random traffic with occasional resets
        do_reset();
        begin
            int pr;
            logic ro, rn;
            pr = 50;
            for (int c = 0; c < 10000; c++) begin
                if (c % 200 == 0) begin
                    pv0 = int'($urandom_range(100));
                    pv1 = int'($urandom_range(100));
                    pr  = int'($urandom_range(100));
                end
                if (q0.size() < 4) q0.push_back(rnd_word());
                if (q1.size() < 4) q1.push_back(rnd_word());
                rn = ($urandom_range(999) != 0);
                ro = rn && (int'($urandom_range(99)) < pr);
                step(ro, rn);
            end
        end
        pv0 = 100; pv1 = 100;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        chk_i("random_drain_sb", sb.size(), 0);
        chk_i("random_drain_q", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/r_forward_arbiter.md
R_FORWARD_ARBITER -- requirements
Module: r_forward_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, input index (0/1) holding round-robin priority after reset.
REQ-002 Parameter: DW, 77, channel word width; bits [68:33] carry the 36-bit address, unused by this block.
REQ-003 ACLK  input  1  clock; all state updates on the rising edge.
REQ-004 ARESETn  input  1  reset; synchronous, active-low.
REQ-005 DATA0i  input  DW  word from filtered source 0.
REQ-006 VALID0i  input  1  source 0 valid.
REQ-007 READY0i  output  1  source 0 ready.
REQ-008 DATA1i  input  DW  word from filtered source 1.
REQ-009 VALID1i  input  1  source 1 valid.
REQ-010 READY1i  output  1  source 1 ready.
REQ-011 DATAo  output  DW  merged word to the downstream slave port.
REQ-012 VALIDo  output  1  merged valid.
REQ-013 READYo  input  1  downstream ready.

Function
REQ-014 The block SHALL merge two address-filtered forward channels onto one output, passing each word unmodified.
REQ-015 The block SHALL hold a registered state: IDLE, GNT0 or GNT1, plus a 1-bit priority pointer PTR.
REQ-016 IDLE: if both VALIDxi are high, go to GNT[PTR]; if exactly one is high, go to that GNTx; otherwise stay in IDLE; READYxi=0 and VALIDo=0 while in IDLE.
REQ-017 GNTx: VALIDo=VALIDxi, DATAo=DATAxi, READYxi=READYo, and READY of the other input=0 (no-skid build).
REQ-018 Handshake in GNTx is VALIDxi&READYo; on a handshake PTR SHALL become the other index (!x).
REQ-019 On a handshake in GNTx, the next state SHALL be GNT(!x) if VALID(!x)i is high, else GNTx if VALIDxi is high, else IDLE.
REQ-020 Without a handshake in GNTx, the state SHALL hold, so a presented word never changes or drops before acceptance.
REQ-021 If VALIDxi deasserts in GNTx without a handshake (upstream protocol violation), the next state SHALL be IDLE.
REQ-022 Latency from IDLE: 1 cycle from the first VALIDxi to VALIDo; back-to-back throughput with contention: 1 word/cycle, strictly alternating.
REQ-023 READY0i and READY1i SHALL never both be 1 in the same cycle.

Reset
REQ-024 While ARESETn=0 at a rising edge: state=IDLE, PTR=PRIO_INIT, VALIDo=0, READY0i=READY1i=0, and all skid registers empty.
REQ-025 Reset mid-transfer SHALL discard the in-flight word; no handshake is reported for it.

Configuration
REQ-026 Macro R_FORWARD_ARBITER_SKID_EN: when defined, a 2-entry skid slice (main+skid registers) SHALL sit between the arbiter and the output.
REQ-027 With the macro: DATAo/VALIDo come from the main register; READYo reaches the arbiter only through the slice (arbiter sees ready = !skid_full); +1 cycle latency; 1 word/cycle sustained; order preserved; no combinational path from READYo to READYxi.
REQ-028 Without the macro: the fully combinational forwarding of REQ-017 applies, with zero added latency.

Verification
REQ-029 Reset, PRIO_INIT=0, VALID0i=VALID1i=1 held, READYo=1 -> outputs alternate D0,D1,D0,D1, first VALIDo at cycle 1, one word per cycle.
REQ-030 Only VALID1i=1 with DATA1i=77'h1_2345_6789_ABCD_EF01, READYo=0 for 5 cycles then 1 -> DATAo stable for all 6 cycles, READY1i high only in the accept cycle.
REQ-031 GNT0 stalled (READYo=0), then VALID1i rises -> grant stays 0 until handshake, then moves to GNT1 the next cycle.
REQ-032 ARESETn=0 for 1 cycle while VALIDo=1 -> next cycle VALIDo=0, state IDLE, PTR=PRIO_INIT.
REQ-033 SKID_EN build, READYo toggling 1,0,1,0 with both inputs valid -> no loss or duplication; the output sequence equals the round-robin order; each READYxi depends only on registered state.
REQ-034 Random VALID/READY for 10k cycles, both builds -> scoreboard matches, READY0i&READY1i never 1.
